fir_filter: RTL and testbench

FIR_FILTER -- requirements
Module: fir_filter

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_saturate.sv | 28 ++
 rtl/fir_filter.sv | 168 ++++++++++++++++
 tb/tb_fir_filter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR helpers: accumulator sizing, default coefficients, saturation classifier.
package fir_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_e;

    localparam int FIR_DEFAULT_TAPS = 3;
    localparam int FIR_DEFAULT_COEFS [FIR_DEFAULT_TAPS] = '{-38, 63, 37};

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Classifies a sign-extended value against the signed range of out_w bits.
    function automatic sat_e saturate(input logic signed [63:0] value, input int out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (value > max_v) begin
            return SAT_POS;
        end
        if (value < min_v) begin
            return SAT_NEG;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/fir_saturate.sv
// Combinational floor shift (arithmetic right by SHIFT) followed by signed saturation.
module fir_saturate
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 7
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    logic signed [IN_WIDTH-1:0] shifted;
    logic signed [63:0]         wide;
    sat_e                       sat;

    always_comb begin
        shifted = din >>> SHIFT;
        wide    = 64'(shifted);
        sat     = saturate(wide, OUT_WIDTH);
        case (sat)
            SAT_POS: dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            SAT_NEG: dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            default: dout = wide[OUT_WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR: delay line, registered products, summing + saturating output stage.
// FIR_COEF_LOAD_EN adds writable coefficients; each sample keeps the coefficients live at its capture.
module fir_filter
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_TAPS   = 3,
    parameter int FRAC_BITS  = 7,
    parameter int COEFS [NUM_TAPS] = FIR_DEFAULT_COEFS,
    localparam int ADDR_WIDTH = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in,
    input  logic                         in_valid,
`ifdef FIR_COEF_LOAD_EN
    input  logic                         coef_wr_en,
    input  logic [ADDR_WIDTH-1:0]        coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
`endif
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);

    logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];
    logic                         x_valid_q, x_valid_d;
    logic signed [COEF_WIDTH-1:0] tap_coef [NUM_TAPS];
    logic signed [PROD_WIDTH-1:0] prod_q [NUM_TAPS];
    logic signed [PROD_WIDTH-1:0] prod_d [NUM_TAPS];
    logic                         valid_s1_q, valid_s1_d;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [DATA_WIDTH-1:0] sat_out;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic                         out_valid_q, out_valid_d;

    always_comb begin
        x_valid_d = in_valid;
        for (int k = 0; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k];
        end
        if (in_valid) begin
            x_d[0] = in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

`ifdef FIR_COEF_LOAD_EN
    // Slot k carries the coefficients c[k..NUM_TAPS-1] as they were when its sample was
    // captured, so a coefficient write never reaches samples already in the delay line.
    localparam int TRI_SIZE = NUM_TAPS * (NUM_TAPS + 1) / 2;

    function automatic int tri_idx(input int k, input int j);
        return k * NUM_TAPS - (k * (k - 1)) / 2 + (j - k);
    endfunction

    logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coef_d [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] snap_q [TRI_SIZE];
    logic signed [COEF_WIDTH-1:0] snap_d [TRI_SIZE];

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef_d[k] = coef_q[k];
            if (coef_wr_en && (coef_wr_addr == ADDR_WIDTH'(k))) begin
                coef_d[k] = coef_wr_data;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < TRI_SIZE; e++) begin
            snap_d[e] = snap_q[e];
        end
        if (in_valid) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                snap_d[tri_idx(0, j)] = coef_q[j];
            end
            for (int k = 1; k < NUM_TAPS; k++) begin
                for (int j = k; j < NUM_TAPS; j++) begin
                    snap_d[tri_idx(k, j)] = snap_q[tri_idx(k - 1, j)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= COEF_WIDTH'(COEFS[k]);
                for (int j = k; j < NUM_TAPS; j++) begin
                    snap_q[tri_idx(k, j)] <= COEF_WIDTH'(COEFS[j]);
                end
            end
        end else begin
            coef_q <= coef_d;
            snap_q <= snap_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap_coef
            assign tap_coef[gi] = snap_q[tri_idx(gi, gi)];
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap_coef
            assign tap_coef[gi] = COEF_WIDTH'(COEFS[gi]);
        end
    endgenerate
`endif

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_prod
            assign prod_d[gi] = PROD_WIDTH'(x_q[gi]) * PROD_WIDTH'(tap_coef[gi]);
        end
    endgenerate

    always_comb begin
        valid_s1_d  = x_valid_q;
        out_valid_d = valid_s1_q;
        acc         = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_WIDTH'(prod_q[k]);
        end
        out_d = valid_s1_q ? sat_out : out_q;
    end

    fir_saturate #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH),
        .SHIFT     (FRAC_BITS)
    ) u_saturate (
        .din  (acc),
        .dout (sat_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            x_valid_q   <= 1'b0;
            valid_s1_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            prod_q      <= prod_d;
            x_valid_q   <= x_valid_d;
            valid_s1_q  <= valid_s1_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: sample-history reference model, per-cycle compare, directed literal checks.
module tb_fir_filter;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] in_s = '0;
    logic              in_valid = 1'b0;
    logic              coef_wr_en = 1'b0;
    logic [1:0]        coef_wr_addr = '0;
    logic signed [7:0] coef_wr_data = '0;
    logic signed [7:0] out;
    logic              out_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_filter dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_s),
        .in_valid     (in_valid),
`ifdef FIR_COEF_LOAD_EN
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
`endif
        .out          (out),
        .out_valid    (out_valid)
    );

    // Reference: each captured sample remembers the coefficient set live when it arrived.
    int cm [N] = '{-38, 63, 37};
    int hx [N] = '{0, 0, 0};
    int hc [N][N];
    bit p1_v = 0, p2_v = 0, e_v = 0;
    int p1_y = 0, p2_y = 0, e_y = 0;
    int m_sum, m_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cm = '{-38, 63, 37};
            for (int i = 0; i < N; i++) begin
                hx[i] = 0;
                hc[i] = cm;
            end
            p1_v = 0; p2_v = 0; e_v = 0;
            p1_y = 0; p2_y = 0; e_y = 0;
        end else begin
            e_v = p2_v;
            if (p2_v) e_y = p2_y;
            p2_v = p1_v;
            p2_y = p1_y;
            p1_v = in_valid;
            if (in_valid) begin
                for (int k = N - 1; k > 0; k--) begin
                    hx[k] = hx[k-1];
                    hc[k] = hc[k-1];
                end
                hx[0] = int'(in_s);
                hc[0] = cm;
                m_sum = 0;
                for (int k = 0; k < N; k++) m_sum += hx[k] * hc[k][k];
                m_q = m_sum / 128;
                if ((m_sum % 128 != 0) && (m_sum < 0)) m_q = m_q - 1;
                if (m_q > 127) m_q = 127;
                if (m_q < -128) m_q = -128;
                p1_y = m_q;
            end
`ifdef FIR_COEF_LOAD_EN
            if (coef_wr_en && (int'(coef_wr_addr) < N)) cm[coef_wr_addr] = int'(coef_wr_data);
`endif
        end
    end

    int got [$];
    bit vq [$];

    always @(negedge clk) begin
        tests++;
        if (out_valid !== e_v) begin
            fails++;
            $display("FAIL out_valid @%0t: got %0b want %0b", $time, out_valid, e_v);
        end
        tests++;
        if (out !== 8'(e_y)) begin
            fails++;
            $display("FAIL out @%0t: got %0d want %0d", $time, out, e_y);
        end
        vq.push_back(out_valid);
        if (out_valid) got.push_back(int'(out));
    end

    task automatic drive(input int v, input bit vld, input bit we = 0, input int wa = 0, input int wd = 0);
        in_s         = 8'(v);
        in_valid     = vld;
        coef_wr_en   = we;
        coef_wr_addr = 2'(wa);
        coef_wr_data = 8'(wd);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int actual, input int want);
        tests++;
        if (actual != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, actual, want);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive(0, 0);
        drive(0, 0);
        rst = 1'b1;
    endtask

    task automatic impulse_check(input string name);
        got.delete();
        drive(64, 1);
        repeat (6) drive(0, 1);
        repeat (3) drive(0, 0);
        check({name, "_count"}, got.size(), 7);
        check({name, "_y0"}, got[0], -19);
        check({name, "_y1"}, got[1], 31);
        check({name, "_y2"}, got[2], 18);
        check({name, "_y3"}, got[3], 0);
        check({name, "_y6"}, got[6], 0);
        $display("[TB] %s: %0d %0d %0d %0d", name, got[0], got[1], got[2], got[3]);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        repeat (500) drive($urandom, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
        check("reset_out", int'(out), 0);
        check("reset_valid", int'(out_valid), 0);
        $display("[TB] reset hold: 500 cycles done");

        rst = 1'b1;
        impulse_check("impulse");

        got.delete();
        drive(5, 1);
        drive(7, 1);
        apply_reset();
        repeat (4) drive(0, 0);
        check("midreset_no_valid", got.size(), 0);
        $display("[TB] mid-pipeline reset: %0d outputs after reset", got.size());

        got.delete();
        repeat (50) drive(127, 1);
        repeat (3) drive(0, 0);
        check("const_count", got.size(), 50);
        check("const_ramp", got[1], 24);
        check("const_settle", got[49], 61);
        $display("[TB] constant 127: settles at %0d", got[49]);

        apply_reset();
        got.delete();
        drive(127, 1); drive(127, 1); drive(-128, 1);
        repeat (3) drive(0, 0);
        check("sat_pos", got[2], 127);
        $display("[TB] saturate high: %0d", got[2]);

        apply_reset();
        got.delete();
        drive(-128, 1); drive(-128, 1); drive(127, 1);
        repeat (3) drive(0, 0);
        check("sat_neg", got[2], -128);
        $display("[TB] saturate low: %0d", got[2]);

        apply_reset();
        got.delete();
        vq.delete();
        drive(64, 1); drive(99, 0); drive(-77, 0); drive(10, 1);
        repeat (3) drive(0, 0);
        begin
            bit exp_vq [7] = '{0, 0, 0, 1, 0, 0, 1};
            for (int i = 0; i < 7; i++) check($sformatf("gap_valid%0d", i), int'(vq[i]), int'(exp_vq[i]));
        end
        check("gap_y0", got[0], -19);
        check("gap_y1", got[1], 28);
        $display("[TB] valid gaps: outputs %0d %0d", got[0], got[1]);

`ifdef FIR_COEF_LOAD_EN
        apply_reset();
        got.delete();
        drive(64, 1, 1, 1, 0);
        repeat (3) drive(0, 1);
        drive(0, 1, 1, 3, 100);
        drive(64, 1);
        repeat (4) drive(0, 1);
        repeat (3) drive(0, 0);
        check("coef_count", got.size(), 10);
        check("coef_old_y0", got[0], -19);
        check("coef_old_y1", got[1], 31);
        check("coef_old_y2", got[2], 18);
        check("coef_new_y0", got[5], -19);
        check("coef_new_y1", got[6], 0);
        check("coef_new_y2", got[7], 18);
        $display("[TB] coef write: first %0d %0d %0d, second %0d %0d %0d",
                 got[0], got[1], got[2], got[5], got[6], got[7]);
`endif

        apply_reset();
        impulse_check("impulse_after_reset");

        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            drive($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3), $urandom);
        end
        repeat (3) drive(0, 0);
        $display("[TB] random: 400 cycles done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
